// File: rtl/fp_norm_seq.sv
// Multi-cycle post-addition normaliser: turns a raw mantissa sum into a normalised
// mantissa and adjusted exponent, shifting left one bit per cycle, with zero/overflow/underflow flags.
module fp_norm_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] in_exponent,
  input  logic [MAN_W:0]   in_mantissa,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] out_exponent,
  output logic [MAN_W-1:0] out_mantissa,
  output logic             out_zero,
  output logic             out_overflow,
  output logic             out_underflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [EXP_W-1:0] EXP_ZERO = {EXP_W{1'b0}};
  localparam logic [EXP_W-1:0] EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};
  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  // A carry with an exponent at or above this would produce the reserved all-ones exponent.
  localparam logic [EXP_W-1:0] EXP_OVF  = EXP_ONES - EXP_ONE;
  localparam logic [MAN_W-1:0] MAN_ZERO = {MAN_W{1'b0}};

  state_t           state_r;

  logic [EXP_W-1:0] ld_exp_s;
  logic [MAN_W-1:0] ld_mant_s;
  logic             ld_zero_s;
  logic             ld_ovf_s;
  logic             ld_unf_s;
  logic             ld_shift_s;

  logic [MAN_W-1:0] shl_mant_s;
  logic [EXP_W-1:0] dec_exp_s;
  logic             norm_hit_s;
  logic             exp_last_s;

  assign in_ready = (state_r == IDLE) && !rst;

  // Classify the incoming sum and compute the values loaded on accept.
  always_comb begin
    ld_exp_s   = in_exponent;
    ld_mant_s  = in_mantissa[MAN_W-1:0];
    ld_zero_s  = 1'b0;
    ld_ovf_s   = 1'b0;
    ld_unf_s   = 1'b0;
    ld_shift_s = 1'b0;
    if (in_mantissa == {(MAN_W+1){1'b0}}) begin
      ld_exp_s  = EXP_ZERO;
      ld_mant_s = MAN_ZERO;
      ld_zero_s = 1'b1;
    end else if (in_mantissa[MAN_W]) begin
      if (in_exponent >= EXP_OVF) begin
        ld_exp_s  = EXP_ONES;
        ld_mant_s = MAN_ZERO;
        ld_ovf_s  = 1'b1;
      end else begin
        // Carry-out: drop the LSB without rounding.
        ld_exp_s  = in_exponent + EXP_ONE;
        ld_mant_s = in_mantissa[MAN_W:1];
      end
    end else if (in_mantissa[MAN_W-1]) begin
      ld_shift_s = 1'b0;
    end else if (in_exponent == EXP_ZERO) begin
      ld_unf_s = 1'b1;
    end else begin
      ld_shift_s = 1'b1;
    end
  end

  // One left-normalisation step on the working registers.
  always_comb begin
    shl_mant_s = {out_mantissa[MAN_W-2:0], 1'b0};
    dec_exp_s  = out_exponent - EXP_ONE;
    norm_hit_s = out_mantissa[MAN_W-2];
    exp_last_s = (out_exponent == EXP_ONE);
  end

  // Control FSM; the result registers double as the shifting working state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      out_valid     <= 1'b0;
      out_exponent  <= EXP_ZERO;
      out_mantissa  <= MAN_ZERO;
      out_zero      <= 1'b0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            out_exponent  <= ld_exp_s;
            out_mantissa  <= ld_mant_s;
            out_zero      <= ld_zero_s;
            out_overflow  <= ld_ovf_s;
            out_underflow <= ld_unf_s;
            out_valid     <= !ld_shift_s;
            state_r       <= ld_shift_s ? SHIFT : DONE;
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          out_mantissa <= shl_mant_s;
          out_exponent <= dec_exp_s;
          if (norm_hit_s) begin
            out_valid <= 1'b1;
            state_r   <= DONE;
          end else if (exp_last_s) begin
            // Exponent reaches zero before the hidden bit arrives: leave denormal.
            out_underflow <= 1'b1;
            out_valid     <= 1'b1;
            state_r       <= DONE;
          end else begin
            state_r <= SHIFT;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_r   <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_norm_seq.sv
// Randomised scoreboard bench for fp_norm_seq: a driver pushes model results on accept,
// a monitor pops and compares them whenever a result is offered.
module tb_fp_norm_seq;
  localparam int EW = 8;
  localparam int MW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [EW-1:0] in_exponent;
  logic [MW:0]   in_mantissa;
  logic          out_valid;
  logic          out_ready;
  logic [EW-1:0] out_exponent;
  logic [MW-1:0] out_mantissa;
  logic          out_zero;
  logic          out_overflow;
  logic          out_underflow;

  fp_norm_seq #(.EXP_W(EW), .MAN_W(MW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_exponent(in_exponent), .in_mantissa(in_mantissa),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_exponent(out_exponent), .out_mantissa(out_mantissa),
    .out_zero(out_zero), .out_overflow(out_overflow), .out_underflow(out_underflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [EW-1:0] e;
    logic [MW-1:0] m;
    logic          z;
    logic          o;
    logic          u;
    int            lat;
    int            n;
  } item_t;

  item_t q[$];
  int    chk_cnt = 0;
  int    pass_cnt = 0;
  bit    mon_en = 1'b0;
  int    stall_n = 0;
  int    bp_pct = 0;
  int    age = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
  endtask

  // Reference: find the leading one, normalise by that distance unless the exponent runs out first.
  function automatic item_t model(input logic [EW-1:0] e, input logic [MW:0] m);
    item_t r;
    int p, k;
    r.e = '0; r.m = '0; r.z = 1'b0; r.o = 1'b0; r.u = 1'b0; r.lat = 1; r.n = 0;
    if (m == '0) begin
      r.z = 1'b1;
    end else if (m[MW]) begin
      if (int'(e) >= (1 << EW) - 2) begin
        r.o = 1'b1;
        r.e = '1;
      end else begin
        r.m = m[MW:1];
        r.e = EW'(int'(e) + 1);
      end
    end else begin
      p = 0;
      for (int i = 0; i < MW; i++) if (m[i]) p = i;
      k = MW - 1 - p;
      if (k <= int'(e)) begin
        r.m = m[MW-1:0] << k;
        r.e = EW'(int'(e) - k);
        r.lat = 1 + k;
      end else begin
        r.m = m[MW-1:0] << e;
        r.e = '0;
        r.u = 1'b1;
        r.lat = 1 + int'(e);
      end
    end
    return r;
  endfunction

  task automatic send(input logic [EW-1:0] e, input logic [MW:0] m);
    item_t it;
    int w;
    w = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_exponent = e;
    in_mantissa = m;
    while (!in_ready && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'(in_ready), 64'(1));
      in_valid = 1'b0;
    end else begin
      it = model(e, m);
      it.n = cyc;
      @(posedge clk);
      q.push_back(it);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Monitor: check in_ready against outstanding work, compare offered results, drive backpressure.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_ready", 64'(in_ready), 64'(q.size() == 0));
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 64'(out_valid), 64'(0));
        end else begin
          if (age == 0) chk("latency", 64'(cyc - q[0].n), 64'(q[0].lat));
          chk("exponent", 64'(out_exponent), 64'(q[0].e));
          chk("mantissa", 64'(out_mantissa), 64'(q[0].m));
          chk("flags", 64'({out_zero, out_overflow, out_underflow}), 64'({q[0].z, q[0].o, q[0].u}));
          out_ready = (age < stall_n) ? 1'b0 : (int'($urandom_range(0, 99)) >= bp_pct);
          if (out_ready) begin
            void'(q.pop_front());
            age = 0;
          end else begin
            age++;
          end
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
        age = 0;
      end
    end
  end

  logic [MW:0] dir_m [7] = '{25'h1800000, 25'h0800000, 25'h0000001, 25'h0100000,
                             25'h0000001, 25'h0000000, 25'h1000000};
  logic [EW-1:0] dir_e [7] = '{8'd100, 8'd50, 8'd0, 8'd100, 8'd5, 8'd77, 8'd254};

  initial begin
    logic [63:0] one;
    logic [EW-1:0] e;
    logic [MW:0] m;
    int pos, w;
    one = 64'd1;
    rst = 1'b1;
    in_valid = 1'b0;
    in_exponent = '0;
    in_mantissa = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_exponent", 64'(out_exponent), 64'(0));
    chk("reset_mantissa", 64'(out_mantissa), 64'(0));
    chk("reset_flags", 64'({out_zero, out_overflow, out_underflow}), 64'(0));
    chk("reset_in_ready", 64'(in_ready), 64'(0));
    rst = 1'b0;
    #1;
    chk("in_ready_after_reset", 64'(in_ready), 64'(1));
    mon_en = 1'b1;

    for (int i = 0; i < 7; i++) send(dir_e[i], dir_m[i]);
    stall_n = 3;
    send(8'd100, 25'h1800000);
    send(8'd100, 25'h0100000);
    stall_n = 0;

    bp_pct = 30;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      pos = int'($urandom_range(0, 26));
      if (pos >= MW + 1) m = '0;
      else m = (MW + 1)'((one << pos) | ({$urandom, $urandom} & ((one << pos) - one)));
      case ($urandom_range(0, 3))
        0: e = EW'($urandom_range(0, 8));
        1: e = EW'($urandom_range(250, 255));
        default: e = EW'($urandom_range(0, 255));
      endcase
      send(e, m);
    end

    bp_pct = 0;
    w = 0;
    while (q.size() != 0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk("drain_empty", 64'(q.size()), 64'(0));
    @(negedge clk);
    mon_en = 1'b0;

    // Abort a long shift with a one-cycle reset.
    @(negedge clk);
    in_valid = 1'b1;
    in_exponent = 8'd100;
    in_mantissa = 25'h0000001;
    chk("rst_test_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_test_busy", 64'(in_ready), 64'(0));
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_exponent", 64'(out_exponent), 64'(0));
    chk("midrst_mantissa", 64'(out_mantissa), 64'(0));
    chk("midrst_flags", 64'({out_zero, out_overflow, out_underflow}), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(0));
    rst = 1'b0;
    #1;
    chk("midrst_release_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    chk("midrst_no_valid", 64'(out_valid), 64'(0));
    chk("midrst_idle_ready", 64'(in_ready), 64'(1));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/fp_norm_seq.md
# fp_norm_seq

Parametrised, multi-cycle post-addition normaliser for the floating-point adder datapath. It sits between the mantissa adder and result packing and converts the raw sum into a normalised mantissa and adjusted exponent. It generalises exponent and mantissa widths, adds a valid/ready handshake, and iterates left-normalisation one bit per cycle. It also detects zero, exponent overflow and exponent underflow instead of looping on them.

## Interface
- `EXP_W`, default 8: exponent width.
- `MAN_W`, default 24: normalised mantissa width, including the hidden bit.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input operand valid.
- `in_ready`  out  1  block can accept; `state==IDLE && !rst`.
- `in_exponent`  in  `EXP_W`  unadjusted exponent.
- `in_mantissa`  in  `MAN_W+1`  raw sum; bit `MAN_W` is the adder carry-out.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_exponent`  out  `EXP_W`  adjusted exponent.
- `out_mantissa`  out  `MAN_W`  normalised mantissa; bit `MAN_W-1` is the hidden bit.
- `out_zero`  out  1  result is zero.
- `out_overflow`  out  1  exponent saturated to all-ones; mantissa forced to 0.
- `out_underflow`  out  1  exponent hit 0 before normalisation; mantissa left denormal.

## Operation
- States are IDLE, SHIFT and DONE. All outputs are registered.
- **Accept:** a transfer happens when `in_valid && in_ready`. The input is classified in priority order:
  1. **Zero:** `in_mantissa==0`. Load exp=0, mant=0, zero=1. Next state DONE.
  2. **Carry:** `in_mantissa[MAN_W]==1`.
     - If `in_exponent >= 2^EXP_W-2`: load exp=all-ones, mant=0, overflow=1.
     - Otherwise: load mant=`in_mantissa[MAN_W:1]` (the LSB is truncated, no rounding) and exp=`in_exponent+1`.
     - Next state DONE.
  3. **Normal:** `in_mantissa[MAN_W-1]==1`. Load mant=`in_mantissa[MAN_W-1:0]` and exp=`in_exponent`. Next state DONE.
  4. **Zero exponent:** `in_exponent==0`. Load the mantissa unchanged, exp=0, underflow=1. Next state DONE.
  5. **Otherwise:** load mant=`in_mantissa[MAN_W-1:0]` and exp=`in_exponent`. Next state SHIFT.
- **SHIFT, every cycle:**
  - mant <= mant<<1 (zero fill); exp <= exp-1.
  - If `mant[MAN_W-2]==1`, go to DONE.
  - Else if `exp==1`, go to DONE and set underflow=1.
  - Else stay in SHIFT.
- **DONE:**
  - `out_valid=1`. Outputs and flags hold stable until `out_ready`.
  - On `out_valid && out_ready`: go to IDLE and clear `out_valid`. `in_ready` rises the following cycle; there is no accept in the handoff cycle.
- **Flags:** at most one of zero, overflow and underflow is set per result. All flags clear on the next accept.
- **Arithmetic:** exponent arithmetic is unsigned `EXP_W` bits. Wrap-around is impossible by construction, because the overflow and underflow checks come first.

## Timing
- **Reset values:**
  - State is IDLE.
  - `out_valid`, `out_exponent`, `out_mantissa` and all flags are 0.
  - `in_ready` is 0 while `rst` is high and 1 in the first cycle after release.
- **Reset mid-operation** (SHIFT or DONE): the operation is aborted, the result is discarded, and the block returns to the reset values at the next edge.
- **Latency:** accept edge to `out_valid` high.
  - Zero, carry, overflow, normal and zero-exponent cases: 1 edge.
  - k leading zeros below bit `MAN_W-1`: 1+k edges.
  - Underflow from SHIFT: 1+`in_exponent` edges.
- **Worst case:** `1+min(MAN_W-1, 2^EXP_W-1)` edges.
- **Throughput:** one result per latency+2 cycles when `out_ready` is held at 1.
- **Backpressure:** `out_ready` low in DONE stalls indefinitely. `in_ready` stays 0 throughout.
- **IDLE output behaviour:** `in_valid` is ignored outside IDLE. `out_ready` is ignored unless `out_valid` is 1. Outputs keep their last values in IDLE while `out_valid=0`.

## Test plan
- **Carry:** `in_mantissa=25'h1800000`, exp 100 -> `out_mantissa=24'hC00000`, exp 101, flags 0, `out_valid` 1 edge after accept.
- **Normal, and zero exponent:**
  - Normal: `25'h0800000`, exp 50 -> `24'h800000`, exp 50, latency 1.
  - Zero exponent: `25'h0000001`, exp 0 -> `out_mantissa=24'h000001`, exp 0, underflow=1, latency 1.
- **Leading zeros:** `25'h0100000`, exp 100 -> `24'h800000`, exp 97, `out_valid` 4 edges after accept; `in_ready` 0 throughout.
- **Underflow:** `25'h0000001`, exp 5 -> `24'h000020`, exp 0, underflow=1, latency 6.
- **Zero and overflow:**
  - Zero: `in_mantissa=0`, exp 77 -> exp 0, mant 0, zero=1.
  - Overflow: `25'h1000000`, exp 254 -> exp 255, mant 0, overflow=1.
- **Handshake and reset:**
  - Hold `out_ready` low 3 cycles in DONE -> outputs stable, `in_ready` 0; back-to-back inputs are accepted only after the handoff plus 1 cycle.
  - Assert `rst` for 1 cycle during SHIFT -> all outputs 0 next edge, `in_ready` 1 the cycle after release.
